// File: rtl/mem_pkg.sv
// Shared types for the load/store unit: access-size encodings, FSM state encoding,
// datapath width and the alignment rule used at request accept.
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_RSVD = 2'b11
    } size_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_MERGE = 3'd2,
        ST_WR    = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

    // The reserved size code is reported as a misaligned access.
    function automatic logic is_misaligned(input size_e size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = offset[0];
            SIZE_WORD: is_misaligned = |offset;
            default:   is_misaligned = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane handling: extracts/extends a sub-word load from a memory word and
// merges sub-word store data into a read word. Purely combinational.
module mem_lane_align
    import mem_pkg::*;
(
    input  size_e              i_size,
    input  logic               i_unsigned,
    input  logic [1:0]         i_offset,
    input  logic [WORD_W-1:0]  i_word,
    input  logic [WORD_W-1:0]  i_wdata,
    output logic [WORD_W-1:0]  o_load_data,
    output logic [WORD_W-1:0]  o_merged
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every output of an always_comb gets a default before the case so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_byte      = i_word[31:24];
        w_half      = i_offset[1] ? i_word[15:0] : i_word[31:16];
        o_load_data = i_word;
        o_merged    = i_word;

        case (i_offset)
            2'd0:    w_byte = i_word[31:24];
            2'd1:    w_byte = i_word[23:16];
            2'd2:    w_byte = i_word[15:8];
            default: w_byte = i_word[7:0];
        endcase

        case (i_size)
            SIZE_BYTE: begin
                o_load_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
                case (i_offset)
                    2'd0:    o_merged[31:24] = i_wdata[7:0];
                    2'd1:    o_merged[23:16] = i_wdata[7:0];
                    2'd2:    o_merged[15:8]  = i_wdata[7:0];
                    default: o_merged[7:0]   = i_wdata[7:0];
                endcase
            end
            SIZE_HALF: begin
                o_load_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
                if (i_offset[1]) o_merged[15:0]  = i_wdata[15:0];
                else             o_merged[31:16] = i_wdata[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one request at a time, fixed-latency memory handshake,
// read-modify-write for sub-word stores, misalignment reported without touching memory.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_LATENCY = 1,
    parameter int MEM_WORDS   = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_write,
    input  logic [1:0]         req_size,
    input  logic               req_unsigned,
    input  logic [WORD_W-1:0]  req_addr,
    input  logic [WORD_W-1:0]  req_wdata,
    output logic               resp_valid,
    output logic [WORD_W-1:0]  resp_rdata,
    output logic               resp_err,
    output logic [WORD_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]  mem_write_data,
    output logic               mem_memread,
    output logic               mem_memwrite,
    input  logic [WORD_W-1:0]  mem_read_data
);

    localparam int              CNT_W    = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    if (MEM_LATENCY < 1 || MEM_WORDS < 1) begin : g_bad_param
        $error("mem_access_unit: MEM_LATENCY and MEM_WORDS must be at least 1");
    end

    state_e             r_state;
    state_e             w_next_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write;
    size_e              r_size;
    logic               r_unsigned;
    logic [1:0]         r_offset;
    logic [WORD_W-1:0]  r_wdata;
    logic [WORD_W-1:0]  r_rdata;

    logic               r_resp_valid;
    logic               r_resp_err;
    logic [WORD_W-1:0]  r_resp_rdata;
    logic [WORD_W-1:0]  r_mem_addr;
    logic [WORD_W-1:0]  r_mem_wdata;
    logic               r_memread;
    logic               r_memwrite;

    size_e              w_req_size;
    logic               w_misaligned;
    logic               w_phase_done;
    logic [WORD_W-1:0]  w_align_word;
    logic [WORD_W-1:0]  w_load_data;
    logic [WORD_W-1:0]  w_merged;

    assign w_req_size   = size_e'(req_size);
    assign w_misaligned = is_misaligned(w_req_size, req_addr[1:0]);
    assign w_phase_done = (r_cnt == CNT_LAST);
    // Loads extend the word as it arrives; the merge works on the word captured in RD.
    assign w_align_word = (r_state == ST_MERGE) ? r_rdata : mem_read_data;

    mem_lane_align u_lane_align (
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .i_offset    (r_offset),
        .i_word      (w_align_word),
        .i_wdata     (r_wdata),
        .o_load_data (w_load_data),
        .o_merged    (w_merged)
    );

    assign req_ready      = (r_state == ST_IDLE);
    assign resp_valid     = r_resp_valid;
    assign resp_err       = r_resp_err;
    assign resp_rdata     = r_resp_rdata;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    assign mem_memread    = r_memread;
    assign mem_memwrite   = r_memwrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    if (w_misaligned)                           w_next_state = ST_RESP;
                    else if (req_write && w_req_size == SIZE_WORD) w_next_state = ST_WR;
                    else                                        w_next_state = ST_RD;
                end
            end
            ST_RD:    if (w_phase_done) w_next_state = r_write ? ST_MERGE : ST_RESP;
            ST_MERGE: w_next_state = ST_WR;
            ST_WR:    if (w_phase_done) w_next_state = ST_RESP;
            ST_RESP:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values, regardless of statement order inside the block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_size       <= SIZE_BYTE;
            r_unsigned   <= 1'b0;
            r_offset     <= 2'b00;
            r_wdata      <= '0;
            r_rdata      <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_memread    <= 1'b0;
            r_memwrite   <= 1'b0;
        end else begin
            if ((r_state == ST_RD || r_state == ST_WR) && !w_phase_done) r_cnt <= r_cnt + 1'b1;
            else                                                          r_cnt <= '0;

            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_write    <= req_write;
                        r_size     <= w_req_size;
                        r_unsigned <= req_unsigned;
                        r_offset   <= req_addr[1:0];
                        r_wdata    <= req_wdata;
                        r_mem_addr <= {2'b00, req_addr[WORD_W-1:2]};
                        case (w_next_state)
                            ST_RD: r_memread <= 1'b1;
                            ST_WR: begin
                                r_memwrite  <= 1'b1;
                                r_mem_wdata <= req_wdata;
                            end
                            default: begin
                                r_resp_valid <= 1'b1;
                                r_resp_err   <= 1'b1;
                                r_resp_rdata <= '0;
                            end
                        endcase
                    end
                end
                ST_RD: begin
                    if (w_phase_done) begin
                        r_memread <= 1'b0;
                        r_rdata   <= mem_read_data;
                        if (!r_write) begin
                            r_resp_valid <= 1'b1;
                            r_resp_rdata <= w_load_data;
                        end
                    end
                end
                ST_MERGE: begin
                    r_memwrite  <= 1'b1;
                    r_mem_wdata <= w_merged;
                end
                ST_WR: begin
                    if (w_phase_done) begin
                        r_memwrite   <= 1'b0;
                        r_resp_valid <= 1'b1;
                        r_resp_rdata <= '0;
                    end
                end
                ST_RESP: begin
                    r_resp_valid <= 1'b0;
                    r_resp_err   <= 1'b0;
                    r_resp_rdata <= '0;
                    r_mem_wdata  <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3,
// each with a small latency-honouring memory model.
module tb_mem_access_unit;

    localparam int L1 = 1;
    localparam int L3 = 3;

    logic        clk = 1'b0;
    logic        rst_n1, rst_n3;
    logic        req_valid1, req_valid3;
    logic        req_write, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;

    logic        req_ready1, resp_valid1, resp_err1, mem_memread1, mem_memwrite1;
    logic [31:0] resp_rdata1, mem_addr1, mem_write_data1, mem_read_data1;
    logic        req_ready3, resp_valid3, resp_err3, mem_memread3, mem_memwrite3;
    logic [31:0] resp_rdata3, mem_addr3, mem_write_data3, mem_read_data3;

    logic [31:0] mem1 [0:15] = '{8: 32'h80FF7F01, default: 32'h0};
    logic [31:0] mem3 [0:15] = '{8: 32'h80FF7F01, default: 32'h0};
    int rc1 = 0, wc1 = 0, rc3 = 0, wc3 = 0;
    int rd_cyc1 = 0, wr_cyc1 = 0, both1 = 0;
    int rd_cyc3 = 0, wr_cyc3 = 0, both3 = 0, a9_cyc3 = 0, rv_cyc3 = 0;

    int total = 0;
    int bad   = 0;

    logic [31:0] t_rdata;
    logic        t_err;
    int          t_lat, t_rdc, t_wrc, t_a9;

    always #5 clk = ~clk;

    mem_access_unit #(.MEM_LATENCY(L1), .MEM_WORDS(256)) dut1 (
        .clk(clk), .rst_n(rst_n1), .req_valid(req_valid1), .req_ready(req_ready1),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid1),
        .resp_rdata(resp_rdata1), .resp_err(resp_err1), .mem_addr(mem_addr1),
        .mem_write_data(mem_write_data1), .mem_memread(mem_memread1),
        .mem_memwrite(mem_memwrite1), .mem_read_data(mem_read_data1)
    );

    mem_access_unit #(.MEM_LATENCY(L3), .MEM_WORDS(256)) dut3 (
        .clk(clk), .rst_n(rst_n3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid3),
        .resp_rdata(resp_rdata3), .resp_err(resp_err3), .mem_addr(mem_addr3),
        .mem_write_data(mem_write_data3), .mem_memread(mem_memread3),
        .mem_memwrite(mem_memwrite3), .mem_read_data(mem_read_data3)
    );

    // Memory models: read data is only valid on the cycle ending the L-th held edge,
    // and a write lands on the L-th edge of the write phase.
    assign mem_read_data1 = (mem_memread1 && rc1 == L1 - 1) ? mem1[mem_addr1[3:0]] : 32'hDEADBEEF;
    assign mem_read_data3 = (mem_memread3 && rc3 == L3 - 1) ? mem3[mem_addr3[3:0]] : 32'hDEADBEEF;

    always @(posedge clk) begin
        rc1 <= mem_memread1 ? rc1 + 1 : 0;
        wc1 <= mem_memwrite1 ? wc1 + 1 : 0;
        if (mem_memwrite1 && wc1 == L1 - 1) mem1[mem_addr1[3:0]] <= mem_write_data1;
        rd_cyc1 <= rd_cyc1 + (mem_memread1 ? 1 : 0);
        wr_cyc1 <= wr_cyc1 + (mem_memwrite1 ? 1 : 0);
        both1   <= both1 + ((mem_memread1 && mem_memwrite1) ? 1 : 0);
    end

    always @(posedge clk) begin
        rc3 <= mem_memread3 ? rc3 + 1 : 0;
        wc3 <= mem_memwrite3 ? wc3 + 1 : 0;
        if (mem_memwrite3 && wc3 == L3 - 1) mem3[mem_addr3[3:0]] <= mem_write_data3;
        rd_cyc3 <= rd_cyc3 + (mem_memread3 ? 1 : 0);
        wr_cyc3 <= wr_cyc3 + (mem_memwrite3 ? 1 : 0);
        both3   <= both3 + ((mem_memread3 && mem_memwrite3) ? 1 : 0);
        a9_cyc3 <= a9_cyc3 + (((mem_memread3 || mem_memwrite3) && mem_addr3 == 32'd9) ? 1 : 0);
        rv_cyc3 <= rv_cyc3 + (resp_valid3 ? 1 : 0);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request; latency = posedges from accept to the edge that samples resp_valid.
    task automatic do_req(input logic sel3, input logic wr, input logic [1:0] sz,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wd);
        int  r0, w0, a0;
        logic got;
        @(negedge clk);
        req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
        check("ready_before_req", sel3 ? req_ready3 : req_ready1, 32'd1);
        r0 = sel3 ? rd_cyc3 : rd_cyc1;
        w0 = sel3 ? wr_cyc3 : wr_cyc1;
        a0 = a9_cyc3;
        if (sel3) req_valid3 = 1'b1; else req_valid1 = 1'b1;
        @(posedge clk);
        #1;
        req_valid1 = 1'b0; req_valid3 = 1'b0;
        // Scramble inputs while busy; the unit must use only what it captured.
        req_write = ~wr; req_size = 2'b11; req_unsigned = ~uns;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5A5A_5A5A;
        got = 1'b0;
        t_lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (sel3 ? resp_valid3 : resp_valid1) begin
                got     = 1'b1;
                t_lat   = i;
                t_rdata = sel3 ? resp_rdata3 : resp_rdata1;
                t_err   = sel3 ? resp_err3 : resp_err1;
                break;
            end
            @(posedge clk);
        end
        if (!got) begin
            check("resp_timeout", 32'd0, 32'd1);
            t_rdata = 32'hxxxx_xxxx;
            t_err   = 1'bx;
        end
        t_rdc = (sel3 ? rd_cyc3 : rd_cyc1) - r0;
        t_wrc = (sel3 ? wr_cyc3 : wr_cyc1) - w0;
        t_a9  = a9_cyc3 - a0;
    endtask

    initial begin
        int rv0, wr0;
        rst_n1 = 1'b0; rst_n3 = 1'b0;
        req_valid1 = 1'b0; req_valid3 = 1'b0;
        req_write = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0;
        #1;
        check("rst_ready", req_ready1, 32'd1);
        check("rst_flags", {resp_valid1, resp_err1, mem_memread1, mem_memwrite1}, 32'd0);
        check("rst_rdata", resp_rdata1, 32'd0);
        check("rst_mem_addr", mem_addr1, 32'd0);
        check("rst_mem_wdata", mem_write_data1, 32'd0);
        repeat (2) @(negedge clk);
        rst_n1 = 1'b1; rst_n3 = 1'b1;

        // Loads against word 8 = 0x80FF7F01 (big-endian lanes)
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("lw_rdata", t_rdata, 32'h80FF7F01);
        check("lw_err", t_err, 32'd0);
        check("lw_lat", t_lat, 32'd2);
        check("lw_rd_cycles", t_rdc, 32'd1);
        check("lw_wr_cycles", t_wrc, 32'd0);
        do_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
        check("lb_21", t_rdata, 32'hFFFFFFFF);
        check("lb_lat", t_lat, 32'd2);
        do_req(1'b0, 1'b0, 2'b00, 1'b1, 32'h20, 32'h0);
        check("lbu_20", t_rdata, 32'h00000080);
        do_req(1'b0, 1'b0, 2'b00, 1'b0, 32'h22, 32'h0);
        check("lb_22", t_rdata, 32'h0000007F);
        do_req(1'b0, 1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
        check("lh_22", t_rdata, 32'h00007F01);
        do_req(1'b0, 1'b0, 2'b01, 1'b1, 32'h20, 32'h0);
        check("lhu_20", t_rdata, 32'h000080FF);
        do_req(1'b0, 1'b0, 2'b01, 1'b0, 32'h20, 32'h0);
        check("lh_20", t_rdata, 32'hFFFF80FF);

        // Sub-word stores: read-modify-write, upper store bits ignored
        do_req(1'b0, 1'b1, 2'b00, 1'b0, 32'h23, 32'h123456AB);
        check("sb_err", t_err, 32'd0);
        check("sb_rdata", t_rdata, 32'd0);
        check("sb_lat", t_lat, 32'd4);
        check("sb_rd_cycles", t_rdc, 32'd1);
        check("sb_wr_cycles", t_wrc, 32'd1);
        check("sb_mem", mem1[8], 32'h80FF7FAB);
        do_req(1'b0, 1'b1, 2'b01, 1'b0, 32'h20, 32'hFFFF1234);
        check("sh_lat", t_lat, 32'd4);
        check("sh_mem", mem1[8], 32'h12347FAB);
        do_req(1'b0, 1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
        check("lhu_22_after_sb", t_rdata, 32'h00007FAB);

        // Misaligned accesses: error in one cycle, memory untouched
        do_req(1'b0, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0);
        check("lw_mis_err", t_err, 32'd1);
        check("lw_mis_rdata", t_rdata, 32'd0);
        check("lw_mis_lat", t_lat, 32'd1);
        check("lw_mis_enables", t_rdc + t_wrc, 32'd0);
        do_req(1'b0, 1'b0, 2'b01, 1'b0, 32'h21, 32'h0);
        check("lh_mis_err", t_err, 32'd1);
        do_req(1'b0, 1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        check("size11_err", t_err, 32'd1);
        do_req(1'b0, 1'b1, 2'b10, 1'b0, 32'h21, 32'hCAFEF00D);
        check("sw_mis_err", t_err, 32'd1);
        check("sw_mis_enables", t_rdc + t_wrc, 32'd0);
        check("sw_mis_mem", mem1[8], 32'h12347FAB);

        // MEM_LATENCY=3: word store then word load, address 9 held 3 cycles per phase
        do_req(1'b1, 1'b1, 2'b10, 1'b0, 32'h24, 32'h12345678);
        check("l3_sw_lat", t_lat, 32'd4);
        check("l3_sw_wr_cycles", t_wrc, 32'd3);
        check("l3_sw_rd_cycles", t_rdc, 32'd0);
        check("l3_sw_addr9_cycles", t_a9, 32'd3);
        check("l3_sw_mem", mem3[9], 32'h12345678);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h24, 32'h0);
        check("l3_lw_rdata", t_rdata, 32'h12345678);
        check("l3_lw_lat", t_lat, 32'd4);
        check("l3_lw_rd_cycles", t_rdc, 32'd3);
        check("l3_lw_addr9_cycles", t_a9, 32'd3);

        // Reset during the second RD cycle of a sub-word store: no response, no write
        @(negedge clk);
        req_write = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
        req_addr = 32'h24; req_wdata = 32'h000000CD;
        req_valid3 = 1'b1;
        rv0 = rv_cyc3;
        wr0 = wr_cyc3;
        @(posedge clk);
        #1 req_valid3 = 1'b0;
        @(posedge clk);
        #2 rst_n3 = 1'b0;
        #1;
        check("midrst_ready", req_ready3, 32'd1);
        check("midrst_flags", {resp_valid3, resp_err3, mem_memread3, mem_memwrite3}, 32'd0);
        check("midrst_rdata", resp_rdata3, 32'd0);
        check("midrst_mem_addr", mem_addr3, 32'd0);
        check("midrst_mem_wdata", mem_write_data3, 32'd0);
        repeat (2) @(negedge clk);
        rst_n3 = 1'b1;
        repeat (6) @(negedge clk);
        check("midrst_no_resp", rv_cyc3 - rv0, 32'd0);
        check("midrst_no_write", wr_cyc3 - wr0, 32'd0);
        check("midrst_mem", mem3[9], 32'h12345678);
        do_req(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        check("postrst_lw_rdata", t_rdata, 32'h80FF7F01);
        check("postrst_lw_lat", t_lat, 32'd4);

        check("never_both_l1", both1, 32'd0);
        check("never_both_l3", both3, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter MEM_LATENCY, default 1: clock edges a memory address/command is held before read data is sampled or a write is considered done.
REQ-002 SHALL have parameter MEM_WORDS, default 256: data memory depth in 32-bit words.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port clk  in  1  rising-edge clock.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port req_valid  in  1  pipeline MEM-stage request present.
REQ-007 SHALL have port req_ready  out  1  unit can accept a request; a request is accepted on an edge where req_valid=1 and req_ready=1.
REQ-008 SHALL have port req_write  in  1  1=store, 0=load.
REQ-009 SHALL have port req_size  in  2  00=byte, 01=half, 10=word; 11 is treated as misaligned.
REQ-010 SHALL have port req_unsigned  in  1  zero-extend sub-word loads.
REQ-011 SHALL have port req_addr  in  32  byte address.
REQ-012 SHALL have port req_wdata  in  32  store data, right-justified for sub-word stores.
REQ-013 SHALL have port resp_valid  out  1  one-cycle completion pulse, with no backpressure.
REQ-014 SHALL have port resp_rdata  out  32  load result; 0 for stores and errors.
REQ-015 SHALL have port resp_err  out  1  misaligned access, valid with resp_valid.
REQ-016 SHALL have port mem_addr  out  32  word index, equal to req_addr[31:2].
REQ-017 SHALL have port mem_write_data  out  32  word to store.
REQ-018 SHALL have port mem_memread  out  1  memory read enable.
REQ-019 SHALL have port mem_memwrite  out  1  memory write enable.
REQ-020 SHALL have port mem_read_data  in  32  memory read word.

Function
REQ-021 SHALL implement states IDLE, RD, MERGE, WR, RESP; req_ready=1 only in IDLE.
REQ-022 SHALL, on accept with misalignment (half with addr[0]=1, word with addr[1:0]!=0, or size 11), go to RESP with resp_err=1 and resp_rdata=0, and assert no memory enable.
REQ-023 SHALL route an accepted aligned load, or a sub-word store, to RD; an aligned word store SHALL go to WR.
REQ-024 SHALL drive mem_addr, mem_memread, mem_memwrite and mem_write_data from registers, all updated on the same edge, and hold them constant for exactly MEM_LATENCY edges per phase.
REQ-025 SHALL, in RD, assert mem_memread=1, then sample mem_read_data on the MEM_LATENCY-th edge.
REQ-026 SHALL, after sampling a load, go to RESP; after sampling for a sub-word store, go to MERGE.
REQ-027 SHALL use big-endian byte lanes: offset 0 maps to bits 31:24 and offset 3 to bits 7:0; half at offset 0 maps to bits 31:16.
REQ-028 SHALL right-justify load results, sign-extending unless req_unsigned=1; word loads SHALL pass the data unchanged.
REQ-029 SHALL, in MERGE (one cycle), replace only the addressed lane(s) of the read word with req_wdata[7:0] or req_wdata[15:0], then go to WR.
REQ-030 SHALL, in WR, assert mem_memwrite=1 with mem_write_data valid for MEM_LATENCY edges, then go to RESP.
REQ-031 SHALL, in RESP, pulse resp_valid=1 for one cycle, then return to IDLE.
REQ-032 SHALL deassert mem_memread and mem_memwrite in IDLE and RESP, and never assert both together.
REQ-033 SHALL produce resp_valid MEM_LATENCY+1 cycles after accept for loads and word stores, 2*MEM_LATENCY+2 for sub-word stores, and 1 for errors.
REQ-034 SHALL count latency with a counter of width clog2(MEM_LATENCY+1); MEM_LATENCY=0 is illegal.
REQ-035 SHALL ignore request inputs while req_ready=0, so inputs are captured only at accept.
REQ-036 SHALL accept back-to-back requests at a peak rate of one per MEM_LATENCY+2 cycles.

Reset
REQ-037 SHALL, while rst_n=0, force state IDLE, req_ready=1, and resp_valid, resp_err, resp_rdata, mem_addr, mem_write_data, mem_memread and mem_memwrite all 0, asynchronously.
REQ-038 SHALL abort any in-flight access on reset mid-operation, issuing no response and performing no partial RMW write.

Structure
REQ-039 SHALL take the size encodings, state encoding and WORD_W=32 from the shared package mem_pkg.
REQ-040 SHALL place lane extract/sign-extend and store merge in one combinational sub-module, mem_lane_align.

Verification (bench memory model honours MEM_LATENCY; word 8 preloaded 0x80FF7F01)
REQ-041 SHALL verify: LW 0x20 -> resp_rdata=0x80FF7F01, resp_err=0, resp_valid 2 cycles after accept (MEM_LATENCY=1).
REQ-042 SHALL verify: LB 0x21 -> 0xFFFFFFFF; LBU 0x20 -> 0x00000080; LH 0x22 -> 0x00007F01; LHU 0x20 -> 0x000080FF.
REQ-043 SHALL verify: SB 0xAB at 0x23 -> one read pulse then one write pulse, word 8 becomes 0x80FF7FAB, resp_valid 4 cycles after accept.
REQ-044 SHALL verify: LW 0x22 -> resp_err=1, resp_rdata=0 one cycle after accept, with mem_memread and mem_memwrite never asserted.
REQ-045 SHALL verify, with MEM_LATENCY=3: SW 0x12345678 to 0x24 then LW 0x24 -> 0x12345678, with mem_addr=9 held for 3 cycles in each phase.
REQ-046 SHALL verify: rst_n low in RD phase 2 -> all outputs 0 immediately, no resp_valid, req_ready=1 after release, and the next LW completes normally.
